// File: rtl/dot_product_engine.sv
// Signed fixed-point dot product for one CNN filter window.
// It accumulates TAPS pixel/weight products onto a bias, LANES taps per beat.
// The sum is then rescaled with round-half-up, optionally ReLU'd, and saturated to OUT_W.
// Valid/ready handshakes on both the window side and the result side.

// One MAC lane: full-precision signed product.
module dpe_lane #(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0]   a,
  input  logic signed [DATA_W-1:0]   b,
  output logic signed [2*DATA_W-1:0] p
);
  assign p = a * b;
endmodule

module dot_product_engine #(
  parameter int DATA_W    = 16,
  parameter int TAPS      = 9,
  parameter int LANES     = 3,
  parameter int ACC_W     = 40,
  parameter int FRAC_BITS = 8,
  parameter int OUT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TAPS*DATA_W-1:0] img_in,
  input  logic [TAPS*DATA_W-1:0] filt_in,
  input  logic [2*DATA_W-1:0]    bias_in,
  input  logic                   relu_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_sat
);
  localparam int BEATS = (TAPS + LANES - 1) / LANES;
  localparam int PAD   = BEATS * LANES;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'((1 << FRAC_BITS) >> 1);
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [ACC_W:0] MINV = -MAXV - (ACC_W+1)'(1);

  // An undersized accumulator could silently wrap, so refuse to build it.
  if (ACC_W < 2*DATA_W + $clog2(TAPS) + 1) begin : g_acc_chk
    $error("dot_product_engine: ACC_W too small for DATA_W/TAPS");
  end

  typedef enum logic [1:0] {IDLE, MAC, SCALE, DONE} state_t;

  state_t                    state, nxt;
  logic [TAPS*DATA_W-1:0]    img_q, filt_q;
  logic                      relu_q;
  logic signed [ACC_W-1:0]   acc;
  logic [BCW-1:0]            beat;

  logic [PAD*DATA_W-1:0]               img_pad, filt_pad;
  logic [LANES-1:0][DATA_W-1:0]        lane_a, lane_b;
  logic [LANES-1:0][2*DATA_W-1:0]      lane_p;
  logic signed [ACC_W-1:0]             beat_sum;
  logic signed [ACC_W:0]               rnd, r, r_relu;
  logic [OUT_W-1:0]                    sat_val;
  logic                                sat_flag;

  assign in_ready = (state == IDLE);

  // Zero-extend operands to a whole number of beats; padded taps multiply to 0.
  always_comb begin
    img_pad  = '0;
    filt_pad = '0;
    img_pad[TAPS*DATA_W-1:0]  = img_q;
    filt_pad[TAPS*DATA_W-1:0] = filt_q;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_a[l] = img_pad[(32'(beat)*LANES + l)*DATA_W +: DATA_W];
    assign lane_b[l] = filt_pad[(32'(beat)*LANES + l)*DATA_W +: DATA_W];
    dpe_lane #(.DATA_W(DATA_W)) u_lane (
      .a (lane_a[l]),
      .b (lane_b[l]),
      .p (lane_p[l])
    );
  end

  // Sign-extend and sum this beat's lane products.
  always_comb begin
    beat_sum = '0;
    for (int l = 0; l < LANES; l++)
      beat_sum = beat_sum + ACC_W'($signed(lane_p[l]));
  end

  // Round half up, arithmetic shift, optional ReLU, then saturate.
  always_comb begin
    rnd      = $signed({acc[ACC_W-1], acc}) + HALF;
    r        = rnd >>> FRAC_BITS;
    r_relu   = (relu_q && r[ACC_W]) ? '0 : r;
    sat_flag = 1'b0;
    sat_val  = r_relu[OUT_W-1:0];
    if (r_relu > MAXV) begin
      sat_flag = 1'b1;
      sat_val  = MAXV[OUT_W-1:0];
    end else if (r_relu < MINV) begin
      sat_flag = 1'b1;
      sat_val  = MINV[OUT_W-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state logic.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid) nxt = MAC;
      MAC:     if (beat == BCW'(BEATS-1)) nxt = SCALE;
      SCALE:   nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Operand latch, accumulation and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_q     <= '0;
      filt_q    <= '0;
      relu_q    <= 1'b0;
      acc       <= '0;
      beat      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          img_q  <= img_in;
          filt_q <= filt_in;
          relu_q <= relu_en;
          acc    <= ACC_W'($signed(bias_in));
          beat   <= '0;
        end
        MAC: begin
          acc  <= acc + beat_sum;
          beat <= beat + 1'b1;
        end
        SCALE: begin
          out_data  <= sat_val;
          out_sat   <= sat_flag;
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_engine.sv
// Bench for dot_product_engine: two instances are checked against a behavioural model through scoreboards.
// Instance A uses the defaults (9 taps, 3 lanes, 8 fraction bits).
// Instance B uses 10 taps, 3 lanes and no fraction bits, which exercises padded beats.
module tb_dot_product_engine;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         a_in_valid, a_in_ready, a_relu, a_out_valid, a_out_ready, a_out_sat;
  logic [143:0] a_img, a_filt;
  logic [31:0]  a_bias;
  logic [15:0]  a_out_data;

  logic         b_in_valid, b_in_ready, b_relu, b_out_valid, b_out_ready, b_out_sat;
  logic [159:0] b_img, b_filt;
  logic [31:0]  b_bias;
  logic [15:0]  b_out_data;

  dot_product_engine u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .img_in(a_img), .filt_in(a_filt), .bias_in(a_bias), .relu_en(a_relu),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_sat(a_out_sat)
  );

  dot_product_engine #(.TAPS(10), .LANES(3), .FRAC_BITS(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .img_in(b_img), .filt_in(b_filt), .bias_in(b_bias), .relu_en(b_relu),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_sat(b_out_sat)
  );

  typedef struct { logic [15:0] d; logic s; } exp_t;
  exp_t qa[$], qb[$];

  int          pix[10], wt[10];
  logic [31:0] bias;
  logic        relu;
  int          n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact sum in 64 bits, round half up, ReLU, saturate to 16 bits.
  function automatic exp_t model(input int n, input int frac);
    longint acc, r;
    exp_t   e;
    acc = longint'($signed(bias));
    for (int i = 0; i < n; i++) acc += longint'(pix[i]) * longint'(wt[i]);
    if (frac > 0) acc += (longint'(1) << (frac - 1));
    r = acc >>> frac;
    if (relu && r < 0) r = 0;
    if (r > 32767)       begin e.d = 16'h7FFF; e.s = 1'b1; end
    else if (r < -32768) begin e.d = 16'h8000; e.s = 1'b1; end
    else                 begin e.d = 16'(r);   e.s = 1'b0; end
    return e;
  endfunction

  // Present the current window to one instance, push its expectation, and wait for acceptance.
  task automatic accept(input bit sel);
    int n = 0;
    if (!sel) begin
      for (int i = 0; i < 9; i++) begin
        a_img[i*16 +: 16]  = 16'(pix[i]);
        a_filt[i*16 +: 16] = 16'(wt[i]);
      end
      a_bias = bias; a_relu = relu; a_in_valid = 1'b1;
      qa.push_back(model(9, 8));
    end else begin
      for (int i = 0; i < 10; i++) begin
        b_img[i*16 +: 16]  = 16'(pix[i]);
        b_filt[i*16 +: 16] = 16'(wt[i]);
      end
      b_bias = bias; b_relu = relu; b_in_valid = 1'b1;
      qb.push_back(model(10, 0));
    end
    while (!(sel ? b_in_ready : a_in_ready) && n < 50) begin @(posedge clk); #1; n++; end
    chk("accept_timeout", 64'(n < 50), 64'd1);
    @(posedge clk); #1;
    a_in_valid = 1'b0; b_in_valid = 1'b0;
  endtask

  // Wait for the result, check it and its latency, and optionally stall before consuming it.
  task automatic collect(input bit sel, input int hold, input int exp_lat);
    int   lat = 0;
    exp_t e;
    while (!(sel ? b_out_valid : a_out_valid) && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("latency", 64'(lat), 64'(exp_lat));
    e = sel ? qb.pop_front() : qa.pop_front();
    chk("out_data", 64'(sel ? b_out_data : a_out_data), 64'(e.d));
    chk("out_sat",  64'(sel ? b_out_sat  : a_out_sat),  64'(e.s));
    for (int h = 0; h < hold; h++) begin
      a_in_valid = 1'b1; a_img = ~a_img; a_filt = a_filt ^ 144'h5A5A;
      @(posedge clk); #1;
      chk("hold_data",     64'(a_out_data),  64'(e.d));
      chk("hold_valid",    64'(a_out_valid), 64'd1);
      chk("hold_in_ready", 64'(a_in_ready),  64'd0);
    end
    if (sel) b_out_ready = 1'b1; else a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0; b_out_ready = 1'b0;
    chk("valid_drop", 64'(sel ? b_out_valid : a_out_valid), 64'd0);
    chk("ready_back", 64'(sel ? b_in_ready : a_in_ready), 64'd1);
  endtask

  task automatic rand_window();
    for (int i = 0; i < 10; i++) begin
      pix[i] = $signed(16'($urandom));
      wt[i]  = $signed(16'($urandom));
    end
    bias = $urandom;
    relu = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    a_in_valid = 0; a_out_ready = 0; a_img = '0; a_filt = '0; a_bias = '0; a_relu = 0;
    b_in_valid = 0; b_out_ready = 0; b_img = '0; b_filt = '0; b_bias = '0; b_relu = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(a_in_ready),  64'd1);
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_out_data",  64'(a_out_data),  64'd0);
    chk("rst_out_sat",   64'(a_out_sat),   64'd0);
    chk("rst_b_valid",   64'(b_out_valid), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ramp pixels against -2.0 weights with a +1.0 bias: expect -89.
    for (int i = 0; i < 10; i++) begin pix[i] = i + 1; wt[i] = -512; end
    bias = 32'h0000_0100; relu = 1'b0;
    accept(0); collect(0, 0, 4);
    chk("t2_const", 64'(a_out_data), 64'hFFA7);
    // The same window with ReLU: clamps to 0 and does not count as saturation.
    relu = 1'b1;
    accept(0); collect(0, 0, 4);

    // Largest positive and largest negative sums saturate.
    for (int i = 0; i < 10; i++) begin pix[i] = 32767; wt[i] = 32767; end
    bias = 0; relu = 0;
    accept(0); collect(0, 0, 4);
    for (int i = 0; i < 10; i++) wt[i] = -32767;
    accept(0); collect(0, 0, 4);

    repeat (4) begin rand_window(); accept(0); collect(0, 0, 4); end

    // Instance B: all ones over 10 taps gives 10, with 4 beats and latency 5.
    for (int i = 0; i < 10; i++) begin pix[i] = 1; wt[i] = 1; end
    bias = 0; relu = 0;
    accept(1); collect(1, 0, 5);
    for (int i = 0; i < 10; i++) begin pix[i] = i + 1; wt[i] = -512; end
    bias = 32'h0000_0100; relu = 1'b1;
    accept(1); collect(1, 0, 5);
    relu = 1'b0;
    accept(1); collect(1, 0, 5);
    repeat (4) begin rand_window(); accept(1); collect(1, 0, 5); end

    // Downstream stall with upstream pressure, then the next window follows.
    rand_window();
    accept(0); collect(0, 7, 4);
    rand_window();
    accept(0); collect(0, 0, 4);

    // Reset during the second MAC beat discards the window.
    rand_window();
    accept(0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid",    64'(a_out_valid), 64'd0);
    chk("abort_in_ready", 64'(a_in_ready),  64'd1);
    chk("abort_data",     64'(a_out_data),  64'd0);
    void'(qa.pop_back());
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (a_out_valid) seen++; end
    chk("abort_no_output", 64'(seen), 64'd0);
    chk("abort_idle",      64'(a_in_ready), 64'd1);
    for (int i = 0; i < 10; i++) begin pix[i] = 3 * i - 7; wt[i] = 100 - 25 * i; end
    bias = 32'hFFFF_F000; relu = 0;
    accept(0); collect(0, 0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
